// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared widths, divide-op bit indices, divider FSM state
// encodings, ALU op indices and the ALU helper used by the execute stage.
//   DS_TO_ES_BUS_WD  decode -> execute bus width (152)
//   ES_TO_MS_BUS_WD  execute -> memory bus width (71)
//   ES_TO_DS_BYPASS  execute -> decode bypass width (39)
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 152;
    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int ES_TO_DS_BYPASS = 39;
    localparam int DIV_CYCLES      = 32;

    // div_op bit indices
    localparam int DIV_W  = 0;
    localparam int MOD_W  = 1;
    localparam int DIV_WU = 2;
    localparam int MOD_WU = 3;

    // divider FSM states
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // alu_op bit indices
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef struct packed {
        logic [3:0]  div_op;
        logic [11:0] alu_op;
        logic        load_op;
        logic        mem_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_src1;
        logic [31:0] alu_src2;
        logic [31:0] rkd_value;
        logic [31:0] pc;
    } ds_to_es_t;

    // One-hot alu_op: each enabled op ORs its result in, so an all-zero op
    // yields zero rather than a stale value.
    function automatic logic [31:0] alu_calc(input logic [11:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  sh;
        sh = b[4:0];
        r  = '0;
        if (op[ALU_ADD])  r = r | (a + b);
        if (op[ALU_SUB])  r = r | (a - b);
        if (op[ALU_SLT])  r = r | {31'd0, ($signed(a) < $signed(b))};
        if (op[ALU_SLTU]) r = r | {31'd0, (a < b)};
        if (op[ALU_AND])  r = r | (a & b);
        if (op[ALU_NOR])  r = r | ~(a | b);
        if (op[ALU_OR])   r = r | (a | b);
        if (op[ALU_XOR])  r = r | (a ^ b);
        if (op[ALU_SLL])  r = r | (a << sh);
        if (op[ALU_SRL])  r = r | (a >> sh);
        if (op[ALU_SRA])  r = r | 32'($signed(a) >>> sh);
        if (op[ALU_LUI])  r = r | b;
        return r;
    endfunction

endpackage

// File: rtl/exe_stage_div.sv
// es_divider: iterative 32-bit signed/unsigned divider, one restoring
// shift-subtract step per cycle.
//   start/sign_op/dividend/divisor : request, sampled in IDLE
//   ack                            : DONE -> IDLE handoff
//   busy/done                      : FSM in BUSY / DONE
//   quotient/remainder             : sign-fixed results, stable in DONE
// Optional: ES_DIV_EARLY_EXIT_EN skips the iteration when the answer is
// trivial (divisor zero or |dividend| < |divisor|).
module es_divider
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sign_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [1:0]  state_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] quo_reg;        // dividend bits shifted out, quotient shifted in
    logic [31:0] rem_reg;
    logic [31:0] dvs_reg;
    logic [31:0] dividend_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic        dvz_reg;

    logic        dividend_neg, divisor_neg, div_zero, early_exit, step_ge;
    logic [31:0] dividend_mag, divisor_mag, step_diff;
    logic [32:0] step_trial;

    assign dividend_neg = sign_op & dividend[31];
    assign divisor_neg  = sign_op & divisor[31];
    assign dividend_mag = dividend_neg ? (32'd0 - dividend) : dividend;
    assign divisor_mag  = divisor_neg  ? (32'd0 - divisor)  : divisor;
    assign div_zero     = (divisor == 32'd0);

`ifdef ES_DIV_EARLY_EXIT_EN
    assign early_exit = div_zero | (dividend_mag < divisor_mag);
`else
    assign early_exit = 1'b0;
`endif

    // When step_ge holds the difference is below the divisor, so 32 bits suffice.
    assign step_trial = {rem_reg, quo_reg[31]};
    assign step_ge    = (step_trial >= {1'b0, dvs_reg});
    assign step_diff  = step_trial[31:0] - dvs_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= DIV_IDLE;
            cnt_reg      <= '0;
            quo_reg      <= '0;
            rem_reg      <= '0;
            dvs_reg      <= '0;
            dividend_reg <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dvz_reg      <= 1'b0;
        end else begin
            case (state_reg)
                DIV_IDLE: begin
                    if (start) begin
                        dvs_reg      <= divisor_mag;
                        dividend_reg <= dividend;
                        neg_q_reg    <= dividend_neg ^ divisor_neg;
                        neg_r_reg    <= dividend_neg;
                        dvz_reg      <= div_zero;
                        cnt_reg      <= '0;
                        if (early_exit) begin
                            quo_reg   <= '0;
                            rem_reg   <= dividend_mag;
                            state_reg <= DIV_DONE;
                        end else begin
                            quo_reg   <= dividend_mag;
                            rem_reg   <= '0;
                            state_reg <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem_reg <= step_ge ? step_diff : step_trial[31:0];
                    quo_reg <= {quo_reg[30:0], step_ge};
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'(DIV_CYCLES - 1))
                        state_reg <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (ack)
                        state_reg <= DIV_IDLE;
                end
                default: state_reg <= DIV_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == DIV_BUSY);
    assign done = (state_reg == DIV_DONE);

    // Divide by zero overrides the iteration so all four ops agree regardless
    // of the sign of the dividend.
    assign quotient  = dvz_reg   ? 32'hFFFF_FFFF :
                       neg_q_reg ? (32'd0 - quo_reg) : quo_reg;
    assign remainder = dvz_reg   ? dividend_reg :
                       neg_r_reg ? (32'd0 - rem_reg) : rem_reg;

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage pipeline (decode -> execute -> memory).
//   ms_allowin / es_allowin           : pipeline handshake
//   ds_to_es_valid / ds_to_es_bus     : instruction from decode
//   es_to_ms_valid / es_to_ms_bus     : {load_op, gr_we, dest, es_result, pc}
//   data_sram_en/we/addr/wdata        : data SRAM request, issued in handoff cycle
//   es_to_ds_bypass                   : {valid&gr_we, valid&load_op, dest, es_result}
// reset is asynchronous, active low. Optional macro ES_DIV_EARLY_EXIT_EN
// (in es_divider) shortens trivial divides to a single stall cycle.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata,
    output logic [ES_TO_DS_BYPASS-1:0] es_to_ds_bypass
);

    logic      es_valid_reg;
    ds_to_es_t ds_bus_reg;

    logic        es_ready_go, is_div, rem_sel, div_start;
    logic        div_busy, div_done;
    logic [31:0] alu_result, div_quo, div_rem, div_result, es_result;

    assign is_div      = |ds_bus_reg.div_op;
    assign rem_sel     = ds_bus_reg.div_op[MOD_W] | ds_bus_reg.div_op[MOD_WU];
    assign es_ready_go = is_div ? div_done : 1'b1;
    assign es_allowin  = ~es_valid_reg | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid_reg & es_ready_go;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            es_valid_reg <= 1'b0;
            ds_bus_reg   <= '0;
        end else begin
            if (es_allowin)
                es_valid_reg <= ds_to_es_valid;
            if (ds_to_es_valid & es_allowin)
                ds_bus_reg <= ds_to_es_bus;
        end
    end

    assign alu_result = alu_calc(ds_bus_reg.alu_op, ds_bus_reg.alu_src1, ds_bus_reg.alu_src2);

    // The divider only samples start in IDLE; the busy/done gating keeps the
    // request from re-firing on the instruction already being divided.
    assign div_start = es_valid_reg & is_div & ~div_busy & ~div_done;

    es_divider u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .sign_op   (ds_bus_reg.div_op[DIV_W] | ds_bus_reg.div_op[MOD_W]),
        .dividend  (ds_bus_reg.alu_src1),
        .divisor   (ds_bus_reg.alu_src2),
        .ack       (ms_allowin),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign div_result = rem_sel ? div_rem : div_quo;
    assign es_result  = is_div ? div_result : alu_result;

    // Request only in the handoff cycle so a held stage never repeats it.
    assign data_sram_en = es_valid_reg & (ds_bus_reg.load_op | ds_bus_reg.mem_we)
                        & es_ready_go & ms_allowin;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sram_we
            assign data_sram_we[gi] = ds_bus_reg.mem_we & data_sram_en;
        end
    endgenerate

    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = ds_bus_reg.rkd_value;

    assign es_to_ms_bus = {ds_bus_reg.load_op, ds_bus_reg.gr_we, ds_bus_reg.dest,
                           es_result, ds_bus_reg.pc};

    // Valid through a divide stall; decode must stall on its own when the
    // bypassed value is not yet final.
    assign es_to_ds_bypass = {es_valid_reg & ds_bus_reg.gr_we,
                              es_valid_reg & ds_bus_reg.load_op,
                              ds_bus_reg.dest, es_result};

endmodule
